store_buffer: RTL and testbench

- Write-back store buffer directly upstream of the data-memory stage.
- Accepts stores from the EX/MEM boundary and queues them FIFO. Drains one store per cycle into the data memory whenever that cycle has no load.
- Forwards buffered store data to loads that hit a pending word.
- Raises a stall for partially covered loads.
- Keeps the same byte-lane sel encoding as the data memory: 00 none, 01 byte, 10 half, 11 word, lanes low-aligned.

---
 rtl/store_buffer.sv | 135 +++++++++++++
 tb/tb_store_buffer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - FIFO write-back store buffer with youngest-match load forwarding
//
// Sits upstream of the data memory. Stores are queued in issue order and
// drain one per cycle whenever no load occupies the memory stage. Loads
// that hit a buffered word are served from the youngest matching entry.
// A load that the youngest entry covers only partially is stalled.
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   st_valid, st_addr, st_data, st_sel store request (sel 00 = no-op)
//   st_ready                           buffer has a free entry
//   ld_valid, ld_addr, ld_sel          load lookup in the memory stage
//   ld_hit, ld_data, ld_stall          forwarding result
//   mem_write, mem_addr, mem_din,
//   mem_sel                            drain port to the data memory
//   empty                              no pending stores

module store_buffer #(
    parameter int DEPTH   = 4,
    parameter int WORD_AW = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_valid,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [1:0]  st_sel,
    output logic        st_ready,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    input  logic [1:0]  ld_sel,
    output logic        ld_hit,
    output logic [31:0] ld_data,
    output logic        ld_stall,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic [1:0]  mem_sel,
    output logic        empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      ent_addr [DEPTH];
    logic [31:0]      ent_data [DEPTH];
    logic [1:0]       ent_sel  [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic             enq;
    logic             deq;

    logic             match;
    logic [1:0]       m_sel;
    logic [31:0]      m_data;
    logic [PTR_W-1:0] idx;
    logic             ld_active;

    // Only the word-index bits take part in the lookup.
    logic             unused_ld_bits;
    assign unused_ld_bits = ^{ld_addr[31:WORD_AW+2], ld_addr[1:0]};

    assign st_ready  = (count < CNT_W'(DEPTH));
    assign empty     = (count == '0);
    // Loads own the memory port; draining only happens in load-free cycles.
    assign mem_write = (count != '0) && !ld_valid;
    assign mem_addr  = ent_addr[head];
    assign mem_din   = ent_data[head];
    assign mem_sel   = ent_sel[head];

    assign enq = st_valid && st_ready && (st_sel != 2'b00);
    assign deq = mem_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= tail + 1'b1;
            if (deq) head <= head + 1'b1;
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset: count gates validity.
    always_ff @(posedge clk) begin
        if (enq) begin
            ent_addr[tail] <= st_addr;
            ent_data[tail] <= st_data;
            ent_sel[tail]  <= st_sel;
        end
    end

    // Walk entries oldest to youngest; the last match seen is the youngest.
    always_comb begin
        match  = 1'b0;
        m_sel  = 2'b00;
        m_data = '0;
        idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) &&
                (ent_addr[idx][WORD_AW+1:2] == ld_addr[WORD_AW+1:2])) begin
                match  = 1'b1;
                m_sel  = ent_sel[idx];
                m_data = ent_data[idx];
            end
        end
    end

    assign ld_active = ld_valid && (ld_sel != 2'b00);

    always_comb begin
        ld_hit   = ld_active && match && (m_sel >= ld_sel);
        ld_stall = ld_active && match && (m_sel <  ld_sel);
        ld_data  = '0;
        if (ld_hit) begin
            case (ld_sel)
                2'b01:   ld_data = {24'h0, m_data[7:0]};
                2'b10:   ld_data = {16'h0, m_data[15:0]};
                2'b11:   ld_data = m_data;
                default: ld_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - table-driven bench for store_buffer

module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_sel;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [1:0]  ld_sel;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        ld_stall;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [1:0]  mem_sel;
    logic        empty;

    int n_cmp = 0;
    int n_bad = 0;

    store_buffer #(.DEPTH(4), .WORD_AW(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_sel(st_sel),
        .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_sel(ld_sel),
        .ld_hit(ld_hit), .ld_data(ld_data), .ld_stall(ld_stall),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_din(mem_din), .mem_sel(mem_sel),
        .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stv;
        logic [31:0] sta;
        logic [31:0] std;
        logic [1:0]  sts;
        logic        ldv;
        logic [31:0] lda;
        logic [1:0]  lds;
        logic        e_rdy;
        logic        e_hit;
        logic [31:0] e_data;
        logic        e_stall;
        logic        e_mw;
        logic [31:0] e_ma;
        logic [31:0] e_md;
        logic [1:0]  e_ms;
        logic        e_empty;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic stv, input logic [31:0] sta, input logic [31:0] std,
                       input logic [1:0] sts, input logic ldv, input logic [31:0] lda,
                       input logic [1:0] lds, input logic rdy, input logic hit,
                       input logic [31:0] dat, input logic stall, input logic mw,
                       input logic [31:0] ma, input logic [31:0] md, input logic [1:0] ms,
                       input logic emp);
        vec_t v;
        v.stv = stv; v.sta = sta; v.std = std; v.sts = sts;
        v.ldv = ldv; v.lda = lda; v.lds = lds;
        v.e_rdy = rdy; v.e_hit = hit; v.e_data = dat; v.e_stall = stall;
        v.e_mw = mw; v.e_ma = ma; v.e_md = md; v.e_ms = ms; v.e_empty = emp;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        st_valid = 1'b0; st_addr = '0; st_data = '0; st_sel = 2'b00;
        ld_valid = 1'b0; ld_addr = '0; ld_sel = 2'b00;
    endtask

    initial begin
        // idle
        add(0, 0, 0, 0,                    0, 0, 0,        1, 0, 0, 0,              0, 0, 0, 0, 1);
        // single store then drain
        add(1, 'h10, 'hDEADBEEF, 3,        0, 0, 0,        1, 0, 0, 0,              0, 0, 0, 0, 1);
        add(0, 0, 0, 0,                    0, 0, 0,        1, 0, 0, 0,              1, 'h10, 'hDEADBEEF, 3, 0);
        add(0, 0, 0, 0,                    0, 0, 0,        1, 0, 0, 0,              0, 0, 0, 0, 1);
        // fill behind a non-matching load, backpressure, wrap
        add(1, 'h100, 'hA0, 3,             1, 'h300, 3,    1, 0, 0, 0,              0, 0, 0, 0, 1);
        add(1, 'h104, 'hA1, 3,             1, 'h300, 3,    1, 0, 0, 0,              0, 0, 0, 0, 0);
        add(1, 'h108, 'hA2, 3,             1, 'h300, 3,    1, 0, 0, 0,              0, 0, 0, 0, 0);
        add(1, 'h10C, 'hA3, 3,             1, 'h300, 3,    1, 0, 0, 0,              0, 0, 0, 0, 0);
        add(1, 'h110, 'hA4, 3,             1, 'h300, 3,    0, 0, 0, 0,              0, 0, 0, 0, 0);
        add(1, 'h110, 'hA4, 3,             0, 0, 0,        0, 0, 0, 0,              1, 'h100, 'hA0, 3, 0);
        add(1, 'h110, 'hA4, 3,             0, 0, 0,        1, 0, 0, 0,              1, 'h104, 'hA1, 3, 0);
        add(0, 0, 0, 0,                    0, 0, 0,        1, 0, 0, 0,              1, 'h108, 'hA2, 3, 0);
        add(0, 0, 0, 0,                    0, 0, 0,        1, 0, 0, 0,              1, 'h10C, 'hA3, 3, 0);
        add(0, 0, 0, 0,                    0, 0, 0,        1, 0, 0, 0,              1, 'h110, 'hA4, 3, 0);
        add(0, 0, 0, 0,                    0, 0, 0,        1, 0, 0, 0,              0, 0, 0, 0, 1);
        // forwarding: same-cycle not forwarded, then youngest wins
        add(1, 'h20, 'h11111111, 3,        1, 'h20, 3,     1, 0, 0, 0,              0, 0, 0, 0, 1);
        add(1, 'h20, 'h22222222, 3,        1, 'h20, 3,     1, 1, 'h11111111, 0,     0, 0, 0, 0, 0);
        add(0, 0, 0, 0,                    1, 'h20, 3,     1, 1, 'h22222222, 0,     0, 0, 0, 0, 0);
        add(0, 0, 0, 0,                    1, 'h20, 1,     1, 1, 'h22, 0,           0, 0, 0, 0, 0);
        add(0, 0, 0, 0,                    1, 'h22, 2,     1, 1, 'h2222, 0,         0, 0, 0, 0, 0);
        add(0, 0, 0, 0,                    1, 'h24, 3,     1, 0, 0, 0,              0, 0, 0, 0, 0);
        add(0, 0, 0, 0,                    0, 'h20, 3,     1, 0, 0, 0,              1, 'h20, 'h11111111, 3, 0);
        add(0, 0, 0, 0,                    1, 'h20, 0,     1, 0, 0, 0,              0, 0, 0, 0, 0);
        add(0, 0, 0, 0,                    0, 0, 0,        1, 0, 0, 0,              1, 'h20, 'h22222222, 3, 0);
        // partial coverage stall
        add(1, 'h40, 'hAB, 1,              1, 'h300, 3,    1, 0, 0, 0,              0, 0, 0, 0, 1);
        add(0, 0, 0, 0,                    1, 'h40, 3,     1, 0, 0, 1,              0, 0, 0, 0, 0);
        add(0, 0, 0, 0,                    1, 'h40, 1,     1, 1, 'hAB, 0,           0, 0, 0, 0, 0);
        add(0, 0, 0, 0,                    0, 0, 0,        1, 0, 0, 0,              1, 'h40, 'hAB, 1, 0);
        add(0, 0, 0, 0,                    1, 'h40, 3,     1, 0, 0, 0,              0, 0, 0, 0, 1);
        // youngest partial hides an older full word
        add(1, 'h50, 'h55667788, 3,        1, 'h300, 3,    1, 0, 0, 0,              0, 0, 0, 0, 1);
        add(1, 'h50, 'h99, 1,              1, 'h300, 3,    1, 0, 0, 0,              0, 0, 0, 0, 0);
        add(0, 0, 0, 0,                    1, 'h50, 3,     1, 0, 0, 1,              0, 0, 0, 0, 0);
        add(0, 0, 0, 0,                    1, 'h50, 2,     1, 0, 0, 1,              0, 0, 0, 0, 0);
        add(0, 0, 0, 0,                    0, 0, 0,        1, 0, 0, 0,              1, 'h50, 'h55667788, 3, 0);
        add(0, 0, 0, 0,                    1, 'h50, 3,     1, 0, 0, 1,              0, 0, 0, 0, 0);
        add(0, 0, 0, 0,                    0, 0, 0,        1, 0, 0, 0,              1, 'h50, 'h99, 1, 0);
        add(0, 0, 0, 0,                    1, 'h50, 3,     1, 0, 0, 0,              0, 0, 0, 0, 1);
        // sel 00 store is a no-op
        add(1, 'h60, 'h77, 0,              0, 0, 0,        1, 0, 0, 0,              0, 0, 0, 0, 1);
        add(0, 0, 0, 0,                    0, 0, 0,        1, 0, 0, 0,              0, 0, 0, 0, 1);

        // reset then idle
        drive_idle();
        rst_n = 1'b0;
        #12;
        check("rst_empty",    32'(empty),     32'd1);
        check("rst_st_ready", 32'(st_ready),  32'd1);
        check("rst_mem_write",32'(mem_write), 32'd0);
        check("rst_ld_hit",   32'(ld_hit),    32'd0);
        check("rst_ld_stall", 32'(ld_stall),  32'd0);
        check("rst_ld_data",  ld_data,        32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            @(negedge clk);
            st_valid = vecs[k].stv; st_addr = vecs[k].sta;
            st_data  = vecs[k].std; st_sel  = vecs[k].sts;
            ld_valid = vecs[k].ldv; ld_addr = vecs[k].lda; ld_sel = vecs[k].lds;
            #2;
            check($sformatf("v%0d_st_ready", k),  32'(st_ready),  32'(vecs[k].e_rdy));
            check($sformatf("v%0d_ld_hit", k),    32'(ld_hit),    32'(vecs[k].e_hit));
            check($sformatf("v%0d_ld_stall", k),  32'(ld_stall),  32'(vecs[k].e_stall));
            check($sformatf("v%0d_mem_write", k), 32'(mem_write), 32'(vecs[k].e_mw));
            check($sformatf("v%0d_empty", k),     32'(empty),     32'(vecs[k].e_empty));
            if (vecs[k].e_hit || !vecs[k].ldv || vecs[k].lds == 2'b00)
                check($sformatf("v%0d_ld_data", k), ld_data, vecs[k].e_data);
            if (vecs[k].e_mw) begin
                check($sformatf("v%0d_mem_addr", k), mem_addr,      vecs[k].e_ma);
                check($sformatf("v%0d_mem_din", k),  mem_din,       vecs[k].e_md);
                check($sformatf("v%0d_mem_sel", k),  32'(mem_sel),  32'(vecs[k].e_ms));
            end
        end

        // reset mid-operation with three entries pending
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            st_valid = 1'b1; st_addr = 32'h200 + 32'(i * 4);
            st_data = 32'hC0 + 32'(i); st_sel = 2'b11;
            ld_valid = 1'b1; ld_addr = 32'h300; ld_sel = 2'b11;
        end
        @(negedge clk);
        drive_idle();
        #2;
        check("mid_pending_write", 32'(mem_write), 32'd1);
        check("mid_pending_addr",  mem_addr,       32'h200);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_empty",     32'(empty),     32'd1);
        check("mid_rst_mem_write", 32'(mem_write), 32'd0);
        check("mid_rst_st_ready",  32'(st_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #2;
            check($sformatf("post_rst%0d_mem_write", i), 32'(mem_write), 32'd0);
            check($sformatf("post_rst%0d_empty", i),     32'(empty),     32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
